// File: rtl/reverb_if.sv
// Sample-stream bundle for the reverb block: input strobe/sample/mode and output strobe/sample.
interface reverb_if;
  logic               reverb_on;
  logic               ready_in;
  logic signed [15:0] signal_in;
  logic signed [15:0] signal_out;
  logic               ready_out;

  modport master (
    output reverb_on, ready_in, signal_in,
    input  signal_out, ready_out
  );

  modport slave (
    input  reverb_on, ready_in, signal_in,
    output signal_out, ready_out
  );
endinterface

// File: rtl/reverb.sv
// Feedback comb reverb: y = sat16(x + (y[n-DELAY_LEN]*GAIN)>>>8), 2-cycle read/compute pipeline.
// Optional one-pole damping of the delayed sample when REVERB_DAMP_EN is defined.
module reverb #(
  parameter int unsigned DELAY_LEN = 2400,
  parameter int unsigned GAIN      = 128
) (
  input  logic     clk_50m,
  input  logic     rst_n,
  reverb_if.slave  bus
);

  localparam int unsigned AW = (DELAY_LEN > 1) ? $clog2(DELAY_LEN) : 1;
  localparam logic [AW-1:0] LAST_PTR = AW'(DELAY_LEN - 1);
  localparam logic signed [8:0] GAIN_S = {1'b0, 8'(GAIN)};

  typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_CALC} state_t;

  state_t state_q, state_d;
  logic   accept_c, read_c, calc_c;

  logic [AW-1:0]      wr_ptr;
  logic               filled;
  logic               on_q;
  logic signed [15:0] x_q;
  logic signed [15:0] rd_q;
  logic signed [15:0] mem [DELAY_LEN];

  logic signed [15:0] d_c, src_c, sat_c, y_c, wr_data_c;
  logic signed [24:0] prod_c;
  logic signed [16:0] fb_c, sum_c;

  // State register
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next state: strobes arriving outside IDLE are dropped
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bus.ready_in) state_d = ST_READ;
      ST_READ: state_d = ST_CALC;
      ST_CALC: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Pipeline strobes
  always_comb begin
    accept_c = 1'b0;
    read_c   = 1'b0;
    calc_c   = 1'b0;
    case (state_q)
      ST_IDLE: accept_c = bus.ready_in;
      ST_READ: read_c   = 1'b1;
      ST_CALC: calc_c   = 1'b1;
      default: ;
    endcase
  end

  // Delay memory, no reset: unwritten locations are masked by the fill flag
  always_ff @(posedge clk_50m) begin
    if (read_c) rd_q <= mem[wr_ptr];
    if (calc_c) mem[wr_ptr] <= wr_data_c;
  end

  assign d_c = filled ? rd_q : 16'sd0;

`ifdef REVERB_DAMP_EN
  logic signed [15:0] lp_q;
  logic signed [16:0] lp_diff_c;
  logic signed [15:0] lp_next_c;

  assign lp_diff_c = 17'(d_c) - 17'(lp_q);
  assign lp_next_c = 16'(17'(lp_q) + (lp_diff_c >>> 2));
  assign src_c     = lp_next_c;

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n)      lp_q <= 16'sd0;
    else if (calc_c) lp_q <= lp_next_c;
  end
`else
  assign src_c = d_c;
`endif

  // Feedback, sum and clamp; bypass writes silence so the tail drains
  assign prod_c    = 25'(src_c) * 25'(GAIN_S);
  assign fb_c      = 17'(prod_c >>> 8);
  assign sum_c     = 17'(x_q) + fb_c;
  assign sat_c     = (sum_c[16] != sum_c[15]) ? (sum_c[16] ? 16'sh8000 : 16'sh7fff)
                                              : sum_c[15:0];
  assign y_c       = on_q ? sat_c : x_q;
  assign wr_data_c = on_q ? sat_c : 16'sd0;

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      bus.signal_out <= 16'sd0;
      bus.ready_out  <= 1'b0;
      wr_ptr         <= '0;
      filled         <= 1'b0;
      x_q            <= 16'sd0;
      on_q           <= 1'b0;
    end else begin
      bus.ready_out <= 1'b0;
      if (accept_c) begin
        x_q  <= bus.signal_in;
        on_q <= bus.reverb_on;
      end
      if (calc_c) begin
        bus.signal_out <= y_c;
        bus.ready_out  <= 1'b1;
        if (wr_ptr == LAST_PTR) begin
          wr_ptr <= '0;
          filled <= 1'b1;
        end else begin
          wr_ptr <= wr_ptr + AW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_reverb.sv
// Self-checking bench for reverb: reference comb model feeds a scoreboard, tasks add spot checks.
module tb_reverb;

  localparam int L = 2400;
  localparam int G = 128;

  logic clk = 1'b0;
  logic rst_n;

  reverb_if bus ();

  reverb #(.DELAY_LEN(L), .GAIN(G)) dut (
    .clk_50m (clk),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  always #10 clk = ~clk;

  int chk  = 0;
  int pass = 0;
  int hist[$];
  int sb[$];
  int mon_exp;
  int mon_got;

  // Reference: history of values written to the delay line
  function automatic void model_push(input int x, input bit on);
    int n, d, fb, s;
    n  = hist.size();
    d  = (n >= L) ? hist[n-L] : 0;
    fb = (d * G) >>> 8;
    s  = x + fb;
    if (s > 32767)  s = 32767;
    if (s < -32768) s = -32768;
    hist.push_back(on ? s : 0);
    sb.push_back(on ? s : x);
  endfunction

  // Scoreboard: every completed sample is compared against the model
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.ready_out === 1'b1) begin
      chk++;
      mon_got = int'(bus.signal_out);
      if (sb.size() == 0) begin
        $display("FAIL sb_unexpected: ready_out with no pending sample, signal_out=%0d", mon_got);
      end else begin
        mon_exp = sb.pop_front();
        if (mon_got !== mon_exp)
          $display("FAIL sb_sample: got %0d expected %0d", mon_got, mon_exp);
        else
          pass++;
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    hist.delete();
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One sample; mode and data are disturbed right after acceptance
  task automatic send(input int x, input bit on, output int y, output int lat);
    @(negedge clk);
    bus.signal_in = 16'(x);
    bus.reverb_on = on;
    bus.ready_in  = 1'b1;
    model_push(x, on);
    @(posedge clk);
    #1;
    bus.ready_in  = 1'b0;
    bus.reverb_on = ~on;
    bus.signal_in = 16'sh5a5a;
    lat = 0;
    y   = 0;
    for (int i = 1; i <= 6; i++) begin
      @(posedge clk);
      #1;
      if (bus.ready_out === 1'b1) begin
        lat = i;
        y   = int'(bus.signal_out);
        break;
      end
    end
    if (lat == 0) begin
      chk++;
      $display("FAIL send_timeout: no ready_out within 6 cycles for x=%0d", x);
      void'(sb.pop_back());
    end
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    bus.ready_in  = 1'b0;
    bus.reverb_on = 1'b0;
    bus.signal_in = 16'sd0;
    #5;
    chk++;
    if (bus.signal_out !== 16'sd0) $display("FAIL reset_out: got %0d expected 0", bus.signal_out);
    else pass++;
    chk++;
    if (bus.ready_out !== 1'b0) $display("FAIL reset_ready: got %b expected 0", bus.ready_out);
    else pass++;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_bypass();
    int y, lat;
    send(1234, 1'b0, y, lat);
    chk++;
    if (y !== 1234) $display("FAIL bypass_value: got %0d expected 1234", y);
    else pass++;
    chk++;
    if (lat !== 2) $display("FAIL bypass_latency: got %0d expected 2", lat);
    else pass++;
    @(posedge clk);
    #1;
    chk++;
    if (bus.ready_out !== 1'b0) $display("FAIL bypass_pulse_width: got %b expected 0", bus.ready_out);
    else pass++;
    send(-32768, 1'b0, y, lat);
    chk++;
    if (y !== -32768) $display("FAIL bypass_min: got %0d expected -32768", y);
    else pass++;
  endtask

  task automatic test_saturation();
    int y, lat;
    do_reset();
    for (int n = 0; n <= L; n++) begin
      send(30000, 1'b1, y, lat);
      if (n == 0 || n == L-1) begin
        chk++;
        if (y !== 30000) $display("FAIL sat_fill n=%0d: got %0d expected 30000", n, y);
        else pass++;
      end
      if (n == L) begin
        chk++;
        if (y !== 32767) $display("FAIL sat_clamp: got %0d expected 32767", y);
        else pass++;
      end
    end
  endtask

  task automatic test_reset_mid();
    int y, lat, pulses;
    send(1234, 1'b0, y, lat);
    @(negedge clk);
    bus.signal_in = 16'sd999;
    bus.reverb_on = 1'b1;
    bus.ready_in  = 1'b1;
    @(posedge clk);
    #1;
    bus.ready_in = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    hist.delete();
    sb.delete();
    #1;
    chk++;
    if (bus.signal_out !== 16'sd0) $display("FAIL midreset_out: got %0d expected 0", bus.signal_out);
    else pass++;
    chk++;
    if (bus.ready_out !== 1'b0) $display("FAIL midreset_ready: got %b expected 0", bus.ready_out);
    else pass++;
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      if (bus.ready_out === 1'b1) pulses++;
    end
    chk++;
    if (pulses !== 0) $display("FAIL midreset_pulses: got %0d expected 0", pulses);
    else pass++;
    chk++;
    if (bus.signal_out !== 16'sd0) $display("FAIL midreset_hold: got %0d expected 0", bus.signal_out);
    else pass++;
  endtask

  task automatic test_impulse(input int amp, input int e1, input int e2);
    int y, lat;
    for (int n = 0; n <= 2*L; n++) begin
      send((n == 0) ? amp : 0, 1'b1, y, lat);
      if (n == 0) begin
        chk++;
        if (y !== amp) $display("FAIL imp_direct amp=%0d: got %0d expected %0d", amp, y, amp);
        else pass++;
      end
      if (n == 1 || n == L-1 || n == L+1) begin
        chk++;
        if (y !== 0) $display("FAIL imp_quiet amp=%0d n=%0d: got %0d expected 0", amp, n, y);
        else pass++;
      end
      if (n == L) begin
        chk++;
        if (y !== e1) $display("FAIL imp_echo1 amp=%0d: got %0d expected %0d", amp, y, e1);
        else pass++;
      end
      if (n == 2*L) begin
        chk++;
        if (y !== e2) $display("FAIL imp_echo2 amp=%0d: got %0d expected %0d", amp, y, e2);
        else pass++;
      end
    end
  endtask

  task automatic test_back_to_back();
    int y, lat, pulses;
    do_reset();
    @(negedge clk);
    bus.signal_in = 16'sd777;
    bus.reverb_on = 1'b1;
    bus.ready_in  = 1'b1;
    model_push(777, 1'b1);
    @(posedge clk);
    #1;
    bus.signal_in = 16'sd555;
    @(posedge clk);
    #1;
    bus.ready_in = 1'b0;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      if (bus.ready_out === 1'b1) pulses++;
      @(posedge clk);
      #1;
    end
    chk++;
    if (pulses !== 1) $display("FAIL b2b_pulses: got %0d expected 1", pulses);
    else pass++;
    // Echo position proves the pointer moved by exactly one
    for (int n = 1; n <= L; n++) begin
      send(0, 1'b1, y, lat);
      if (n == L-1) begin
        chk++;
        if (y !== 0) $display("FAIL b2b_early_echo: got %0d expected 0", y);
        else pass++;
      end
      if (n == L) begin
        chk++;
        if (y !== 388) $display("FAIL b2b_echo: got %0d expected 388", y);
        else pass++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_saturation();
    test_reset_mid();
    test_impulse(10000, 5000, 2500);
    do_reset();
    test_impulse(-10000, -5000, -2500);
    test_back_to_back();
    repeat (4) @(negedge clk);
    chk++;
    if (sb.size() !== 0) $display("FAIL sb_leftover: %0d samples never completed", sb.size());
    else pass++;
    $display("%0d/%0d checks passed", pass, chk);
    $finish;
  end

endmodule
